// File: rtl/irq_ctrl.sv
// irq_ctrl: machine-mode interrupt controller (mstatus/mie/mip CSRs, MEI>MSI>MTI arbitration, trap req/ack)
module irq_ctrl #(
    parameter int EXT_SYNC_STAGES = 2,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            timer_irq,
    input  logic            sw_irq,
    input  logic            ext_irq,
    input  logic            csr_rd_en,
    input  logic            csr_wr_en,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wr_data,
    output logic [XLEN-1:0] csr_rd_data,
    output logic            csr_hit,
    output logic            trap_req,
    output logic [XLEN-1:0] trap_cause,
    input  logic            trap_ack,
    input  logic            mret
);
    localparam logic [11:0] addr_mstatus = 12'h300;
    localparam logic [11:0] addr_mie = 12'h304;
    localparam logic [11:0] addr_mip = 12'h344;
    localparam logic [XLEN-1:0] ie_mask = XLEN'(12'h888);

    typedef enum logic [1:0] {IDLE, REQ, TRAP} state_t;

    state_t                     state, state_nx;
    logic [EXT_SYNC_STAGES-1:0] ext_sync;
    logic                       st_mie, st_mpie, mie_nx, mpie_nx;
    logic [11:0]                ie_q, mip, pending;
    logic [3:0]                 win_code;
    logic [XLEN-1:0]            cause_nx, rd_val;
    logic                       wr_mstatus, take_ack, latched_pending, owned;

    assign mip = {ext_sync[EXT_SYNC_STAGES-1], 3'b0, timer_irq, 3'b0, sw_irq, 3'b0};
    assign pending = mip & ie_q;
    assign win_code = pending[11] ? 4'd11 : pending[3] ? 4'd3 : 4'd7;
    assign trap_req = state == REQ;
    assign take_ack = trap_req && trap_ack;
    assign wr_mstatus = csr_wr_en && csr_addr == addr_mstatus;
    assign latched_pending = trap_cause[3:0] == 4'd11 ? pending[11] :
                             trap_cause[3:0] == 4'd3  ? pending[3]  : pending[7];
    assign owned = csr_addr == addr_mstatus || csr_addr == addr_mie || csr_addr == addr_mip;
    assign rd_val = csr_addr == addr_mstatus ? XLEN'({st_mpie, 3'b0, st_mie, 3'b0}) :
                    csr_addr == addr_mie     ? XLEN'(ie_q) :
                    csr_addr == addr_mip     ? XLEN'(mip)  : '0;

    // trap FSM: arbitrate in IDLE, hold the latched cause in REQ, wait for mret in TRAP
    always_comb begin
        state_nx = state;
        cause_nx = trap_cause;
        case (state)
            IDLE: if (st_mie && |pending) begin
                state_nx = REQ;
                cause_nx = {1'b1, {(XLEN-5){1'b0}}, win_code};
            end
            REQ: state_nx = trap_ack ? TRAP : (!latched_pending || !st_mie) ? IDLE : REQ;
            TRAP: state_nx = mret ? IDLE : TRAP;
            default: state_nx = IDLE;
        endcase
    end

    // mstatus update order: trap entry, then mret, then software write
    always_comb begin
        mie_nx = take_ack ? 1'b0 : mret ? st_mpie : wr_mstatus ? csr_wr_data[3] : st_mie;
        mpie_nx = take_ack ? st_mie : mret ? 1'b1 : wr_mstatus ? csr_wr_data[7] : st_mpie;
    end

    // architectural state, trap cause and ext_irq synchroniser
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            trap_cause <= '0;
            st_mie <= 1'b0;
            st_mpie <= 1'b0;
            ie_q <= '0;
            ext_sync <= '0;
        end else begin
            state <= state_nx;
            trap_cause <= cause_nx;
            st_mie <= mie_nx;
            st_mpie <= mpie_nx;
            ie_q <= (csr_wr_en && csr_addr == addr_mie) ? 12'(csr_wr_data & ie_mask) : ie_q;
            ext_sync <= {ext_sync[EXT_SYNC_STAGES-2:0], ext_irq};
        end
    end

    // registered CSR read port; data is zero unless a read was issued last cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csr_rd_data <= '0;
            csr_hit <= 1'b0;
        end else begin
            csr_rd_data <= csr_rd_en ? rd_val : '0;
            csr_hit <= (csr_rd_en || csr_wr_en) && owned;
        end
    end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed plus random stimulus against a behavioural interrupt-controller model
module tb_irq_ctrl;
    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst_n, timer_irq, sw_irq, ext_irq, csr_rd_en, csr_wr_en, trap_ack, mret;
    logic [11:0] csr_addr;
    logic [31:0] csr_wr_data, csr_rd_data, trap_cause;
    logic        csr_hit, trap_req;

    irq_ctrl #(.EXT_SYNC_STAGES(S), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .timer_irq(timer_irq), .sw_irq(sw_irq), .ext_irq(ext_irq),
        .csr_rd_en(csr_rd_en), .csr_wr_en(csr_wr_en), .csr_addr(csr_addr), .csr_wr_data(csr_wr_data),
        .csr_rd_data(csr_rd_data), .csr_hit(csr_hit), .trap_req(trap_req), .trap_cause(trap_cause),
        .trap_ack(trap_ack), .mret(mret)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    bit        m_mie, m_mpie, m_req, m_trap, m_hit;
    bit [11:0] m_ie;
    bit [31:0] m_cause, m_rd;
    bit [S-1:0] m_ext;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // reference model: advance one clock using the inputs currently applied
    task automatic model_step();
        bit [11:0] mip, pend;
        int code;
        bit acked, n_mie, n_mpie;
        mip = 12'(m_ext[S-1]) << 11 | 12'(timer_irq) << 7 | 12'(sw_irq) << 3;
        pend = mip & m_ie;
        if (!rst_n) begin
            {m_mie, m_mpie, m_req, m_trap, m_hit} = '0;
            m_ie = 0; m_cause = 0; m_rd = 0; m_ext = 0;
            return;
        end
        m_hit = (csr_rd_en || csr_wr_en) && (csr_addr == 12'h300 || csr_addr == 12'h304 || csr_addr == 12'h344);
        m_rd = !csr_rd_en ? 0 : csr_addr == 12'h300 ? 32'(m_mpie) * 128 + 32'(m_mie) * 8 :
               csr_addr == 12'h304 ? 32'(m_ie) : csr_addr == 12'h344 ? 32'(mip) : 0;
        code = pend[11] ? 11 : pend[3] ? 3 : 7;
        acked = m_req && trap_ack;
        n_mie = m_mie; n_mpie = m_mpie;
        if (acked) begin n_mpie = m_mie; n_mie = 0; end
        else if (mret) begin n_mie = m_mpie; n_mpie = 1; end
        else if (csr_wr_en && csr_addr == 12'h300) begin n_mie = csr_wr_data[3]; n_mpie = csr_wr_data[7]; end
        if (m_req) begin
            if (acked) begin m_req = 0; m_trap = 1; end
            else if (!pend[m_cause[3:0]] || !m_mie) m_req = 0;
        end else if (m_trap) begin
            if (mret) m_trap = 0;
        end else if (m_mie && pend != 0) begin
            m_req = 1;
            m_cause = 32'h8000_0000 + 32'(code);
        end
        m_mie = n_mie; m_mpie = n_mpie;
        if (csr_wr_en && csr_addr == 12'h304) m_ie = csr_wr_data[11:0] & 12'h888;
        m_ext = {m_ext[S-2:0], ext_irq};
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("trap_req", trap_req, m_req);
        chk("csr_hit", csr_hit, m_hit);
        chk("csr_rd_data", csr_rd_data, m_rd);
        if (m_req) chk("trap_cause", trap_cause, m_cause);
        csr_rd_en = 0; csr_wr_en = 0; trap_ack = 0; mret = 0; rst_n = 1;
    endtask

    task automatic rd(input logic [11:0] a);
        csr_rd_en = 1; csr_addr = a;
        cycle();
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_wr_en = 1; csr_addr = a; csr_wr_data = d;
        cycle();
    endtask

    initial begin
        int n;
        {timer_irq, sw_irq, ext_irq, csr_rd_en, csr_wr_en, trap_ack, mret} = '0;
        csr_addr = 0; csr_wr_data = 0; rst_n = 0;
        @(negedge clk);
        rst_n = 0; cycle();
        rst_n = 0; cycle();
        chk("rst_cause", trap_cause, 32'h0);
        rd(12'h300); chk("rst_mstatus", csr_rd_data, 0);
        rd(12'h304); chk("rst_mie", csr_rd_data, 0);
        rd(12'h344); chk("rst_mip", csr_rd_data, 0);
        {timer_irq, sw_irq, ext_irq} = 3'b111;
        for (int i = 0; i < 20; i++) cycle();
        chk("rst_noreq", trap_req, 0);
        {timer_irq, sw_irq, ext_irq} = 3'b000;
        for (int i = 0; i < 3; i++) cycle();
        // timer trap
        wr(12'h304, 32'h80);
        wr(12'h300, 32'h8);
        timer_irq = 1; cycle();
        chk("tmr_req", trap_req, 1);
        chk("tmr_cause", trap_cause, 32'h8000_0007);
        trap_ack = 1; cycle();
        chk("tmr_ackclr", trap_req, 0);
        rd(12'h300); chk("tmr_mstatus", csr_rd_data, 32'h80);
        mret = 1; cycle();
        rd(12'h300); chk("mret_mstatus", csr_rd_data, 32'h88);
        chk("rereq", trap_req, 1);
        // retraction and re-raise
        timer_irq = 0; cycle();
        chk("retract", trap_req, 0);
        timer_irq = 1; cycle();
        chk("reraise_req", trap_req, 1);
        chk("reraise_cause", trap_cause, 32'h8000_0007);
        // ack beats mstatus write; mip is read-only
        trap_ack = 1; wr(12'h300, 32'h88);
        rd(12'h300); chk("ack_beats_wr", csr_rd_data, 32'h80);
        wr(12'h344, 32'hFFF);
        rd(12'h344); chk("mip_ro", csr_rd_data, 32'h80);
        timer_irq = 0; mret = 1; cycle();
        // priority
        wr(12'h304, 32'h888);
        sw_irq = 1; timer_irq = 1; cycle();
        chk("prio_cause", trap_cause, 32'h8000_0003);
        ext_irq = 1;
        for (int i = 0; i < S + 3; i++) cycle();
        chk("prio_hold", trap_cause, 32'h8000_0003);
        trap_ack = 1; cycle();
        mret = 1; cycle();
        cycle();
        chk("prio_ext", trap_cause, 32'h8000_000B);
        // ext latency from a quiet start
        trap_ack = 1; cycle();
        {timer_irq, sw_irq, ext_irq} = 3'b000;
        mret = 1; cycle();
        for (int i = 0; i < 5; i++) cycle();
        ext_irq = 1;
        n = 0;
        while (!trap_req && n < 10) begin cycle(); n++; end
        chk("ext_latency_ok", 32'(n <= S + 1), 1);
        chk("ext_cause", trap_cause, 32'h8000_000B);
        // reset while in TRAP
        trap_ack = 1; cycle();
        rst_n = 0; cycle();
        chk("mid_rst_req", trap_req, 0);
        rd(12'h300); chk("mid_rst_mstatus", csr_rd_data, 0);
        rd(12'h304); chk("mid_rst_mie", csr_rd_data, 0);
        rd(12'h305);
        chk("unk_hit", csr_hit, 0);
        chk("unk_data", csr_rd_data, 0);
        // random phase
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [11:0] addrs [4];
            addrs = '{12'h300, 12'h304, 12'h344, 12'h305};
            if ($urandom_range(0, 11) == 0) timer_irq = ~timer_irq;
            if ($urandom_range(0, 11) == 0) sw_irq = ~sw_irq;
            if ($urandom_range(0, 11) == 0) ext_irq = ~ext_irq;
            r = $urandom_range(0, 9);
            csr_rd_en = r < 3;
            csr_wr_en = r >= 3 && r < 5;
            csr_addr = addrs[$urandom_range(0, 3)];
            csr_wr_data = $urandom;
            trap_ack = m_req ? $urandom_range(0, 3) == 0 : $urandom_range(0, 15) == 0;
            mret = $urandom_range(0, 15) == 0;
            rst_n = $urandom_range(0, 299) != 0;
            cycle();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
